// File: rtl/simd_scheduler_pkg.sv
// Shared definitions for the SIMD core sequencer: state codes, timer sizing
// and a saturating counter helper.
package simd_scheduler_pkg;

  // State encodings are fixed; DECODE must stay at 2.
  typedef enum logic [2:0] {
    SIMD_IDLE    = 3'd0,
    SIMD_FETCH   = 3'd1,
    SIMD_DECODE  = 3'd2,
    SIMD_REQUEST = 3'd3,
    SIMD_WAIT    = 3'd4,
    SIMD_EXECUTE = 3'd5,
    SIMD_UPDATE  = 3'd6,
    SIMD_DONE    = 3'd7
  } simd_state_t;

  localparam int WAIT_TIMEOUT_DEF = 255;
  localparam int TIMER_BITS       = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/simd_scheduler_lsu_tracker.sv
// Tracks which active lanes have completed their memory access during WAIT
// and flags when the wait has run for WAIT_TIMEOUT cycles.
module simd_lsu_tracker
  import simd_scheduler_pkg::*;
#(
  parameter int THREADS      = 4,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               active,
  input  logic [THREADS-1:0] mask,
  input  logic [THREADS-1:0] lsu_done,
  output logic               all_done,
  output logic               timeout
);

  // Timeout fires on the cycle that would bring the count to WAIT_TIMEOUT,
  // so the wait lasts exactly WAIT_TIMEOUT cycles.
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(WAIT_TIMEOUT - 1);

  logic [THREADS-1:0]    pending;
  logic [THREADS-1:0]    done_now;
  logic [TIMER_BITS-1:0] timer;

  // A lane finishing in the current cycle counts toward completion immediately.
  assign done_now = pending | (lsu_done & mask);
  assign all_done = active && (done_now == mask);
  assign timeout  = active && !all_done && (timer == TIMER_LAST);

  // Accumulate completions and count wait cycles; cleared when a request issues.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pending <= '0;
      timer   <= '0;
    end else if (active) begin
      pending <= done_now;
      if (timer != '1) timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/simd_scheduler.sv
// Per-core SIMD sequencer: steps fetch/decode/memory/execute/update, owns the
// PC and retired-instruction count, and reports run completion and faults.
module simd_scheduler
  import simd_scheduler_pkg::*;
#(
  parameter int THREADS      = 4,
  parameter int PC_BITS      = 8,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [THREADS-1:0] thread_mask,
  output logic               fetch_req,
  output logic [PC_BITS-1:0] fetch_addr,
  input  logic               instr_valid,
  input  logic               dec_mem_read,
  input  logic               dec_mem_write,
  input  logic               dec_ret,
  output logic               lsu_start,
  input  logic [THREADS-1:0] lsu_done,
  output logic [2:0]         simd_state,
  output logic [PC_BITS-1:0] pc,
  output logic [15:0]        instr_count,
  output logic               done,
  output logic               error
);

  simd_state_t        state, state_nxt;
  logic               start_q;
  logic               start_acc;
  logic [THREADS-1:0] mask_q;
  logic               mem_op;
  logic               all_done;
  logic               timeout;
  logic               trk_clear;
  logic               trk_active;

  // Only a fresh rising edge of start, and only while not running, begins a run.
  assign start_acc  = start && !start_q && (state == SIMD_IDLE || state == SIMD_DONE);
  assign mem_op     = dec_mem_read || dec_mem_write;
  assign trk_clear  = (state == SIMD_REQUEST) && mem_op;
  assign trk_active = (state == SIMD_WAIT);

  assign simd_state = state;
  assign fetch_addr = pc;

  simd_lsu_tracker #(
    .THREADS      (THREADS),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_lsu_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (trk_clear),
    .active   (trk_active),
    .mask     (mask_q),
    .lsu_done (lsu_done),
    .all_done (all_done),
    .timeout  (timeout)
  );

  // State register plus PC, retire count, fault flag and latched lane mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SIMD_IDLE;
      start_q     <= 1'b0;
      mask_q      <= '0;
      pc          <= '0;
      instr_count <= '0;
      error       <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (start_acc) begin
        pc          <= '0;
        instr_count <= '0;
        error       <= 1'b0;
        mask_q      <= thread_mask;
      end else if (state == SIMD_WAIT && timeout) begin
        error <= 1'b1;
      end else if (state == SIMD_UPDATE) begin
        instr_count <= sat_inc16(instr_count);
        if (!dec_ret) begin
          // Running off the end of program space is a fault, not a wrap.
          if (&pc) error <= 1'b1;
          else     pc    <= pc + 1'b1;
        end
      end
    end
  end

  // Next-state selection; in WAIT, completion takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      SIMD_IDLE, SIMD_DONE: begin
        if (start_acc) state_nxt = (thread_mask == '0) ? SIMD_DONE : SIMD_FETCH;
      end
      SIMD_FETCH:   if (instr_valid) state_nxt = SIMD_DECODE;
      SIMD_DECODE:  state_nxt = SIMD_REQUEST;
      SIMD_REQUEST: state_nxt = mem_op ? SIMD_WAIT : SIMD_EXECUTE;
      SIMD_WAIT: begin
        if (all_done)     state_nxt = SIMD_EXECUTE;
        else if (timeout) state_nxt = SIMD_DONE;
      end
      SIMD_EXECUTE: state_nxt = SIMD_UPDATE;
      SIMD_UPDATE:  state_nxt = (dec_ret || &pc) ? SIMD_DONE : SIMD_FETCH;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    fetch_req = (state == SIMD_FETCH);
    lsu_start = (state == SIMD_REQUEST) && mem_op;
    done      = (state == SIMD_DONE);
  end

endmodule

// File: tb/tb_simd_scheduler.sv
// Bench for simd_scheduler: behavioural fetcher, decoder and LSUs around the
// DUT, with expected run results queued at launch and compared at completion.
module tb_simd_scheduler;
  import simd_scheduler_pkg::*;

  localparam int THREADS = 4;
  localparam int PC_BITS = 4;
  localparam logic [1:0] OP_ADD = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_RET = 2'd3;

  logic               clk;
  logic               rst;
  logic               start;
  logic [THREADS-1:0] thread_mask;
  logic               fetch_req;
  logic [PC_BITS-1:0] fetch_addr;
  logic               instr_valid;
  logic               dec_mem_read;
  logic               dec_mem_write;
  logic               dec_ret;
  logic               lsu_start;
  logic [THREADS-1:0] lsu_done;
  logic [2:0]         simd_state;
  logic [PC_BITS-1:0] pc;
  logic [15:0]        instr_count;
  logic               done;
  logic               error;

  simd_scheduler #(.THREADS(THREADS), .PC_BITS(PC_BITS), .WAIT_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .thread_mask(thread_mask),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr_valid(instr_valid),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_ret(dec_ret),
    .lsu_start(lsu_start), .lsu_done(lsu_done), .simd_state(simd_state),
    .pc(pc), .instr_count(instr_count), .done(done), .error(error)
  );

  typedef struct {
    int cnt; int pc; int err; int pulses; int waits; int cycles;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] prog [16];
  int         lat [4];
  int         lcnt [4];
  int         fetch_lat;
  int         fcnt;
  int         pulses;
  int         waits;
  int         checks;
  int         failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dec_mem_read  = (prog[fetch_addr] == OP_LOAD);
  assign dec_mem_write = (prog[fetch_addr] == OP_STORE);
  assign dec_ret       = (prog[fetch_addr] == OP_RET);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(int c, int p, int e, int pl, int w, int cy);
    exp_t x;
    x.cnt = c; x.pc = p; x.err = e; x.pulses = pl; x.waits = w; x.cycles = cy;
    return x;
  endfunction

  task automatic set_prog(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    for (int i = 0; i < 16; i++) prog[i] = OP_ADD;
    prog[0] = a; prog[1] = b; prog[2] = c;
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  // Fetcher: instr_valid after fetch_lat cycles of fetch_req.
  initial begin
    instr_valid = 1'b0;
    fcnt = 0;
    forever begin
      @(negedge clk);
      if (fetch_req) begin
        instr_valid = (fcnt >= fetch_lat);
        fcnt++;
      end else begin
        instr_valid = 1'b0;
        fcnt = 0;
      end
    end
  end

  // LSUs: lane i pulses lsu_done lat[i] cycles after lsu_start (0 = never).
  initial begin
    lsu_done = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        lsu_done[i] = 1'b0;
        if (lcnt[i] > 0) begin
          lcnt[i]--;
          if (lcnt[i] == 0) lsu_done[i] = 1'b1;
        end
        if (lsu_start) lcnt[i] = lat[i];
      end
    end
  end

  // Monitor: count lsu_start pulses and WAIT cycles.
  initial begin
    pulses = 0;
    waits = 0;
    forever begin
      @(negedge clk);
      #1;
      if (lsu_start) pulses++;
      if (simd_state == 3'd4) waits++;
    end
  end

  task automatic run_prog(input logic [3:0] m, input int flat, input exp_t e, input string tag);
    int   p0, w0, n;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    thread_mask = m; fetch_lat = flat; start = 1'b1;
    p0 = pulses; w0 = waits;
    @(negedge clk);
    start = 1'b0;
    thread_mask = ~m;
    n = 0;
    while (simd_state != 3'd7 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    x = sb.pop_front();
    chk({tag, "_state"}, 32'(simd_state), 32'(7));
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_count"}, 32'(instr_count), x.cnt);
    chk({tag, "_pc"}, 32'(pc), x.pc);
    chk({tag, "_error"}, 32'(error), x.err);
    chk({tag, "_lsu_pulses"}, pulses - p0, x.pulses);
    chk({tag, "_wait_cycles"}, waits - w0, x.waits);
    if (x.cycles != 0) chk({tag, "_cycles"}, n + 1, x.cycles);
  endtask

  initial begin
    int n, p0;
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; thread_mask = '0; fetch_lat = 1;
    set_lat(0, 0, 0, 0);
    set_prog(OP_ADD, OP_ADD, OP_ADD);
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(simd_state), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_count", 32'(instr_count), 32'(0));
    chk("rst_fetch_req", 32'(fetch_req), 32'(0));
    chk("rst_lsu_start", 32'(lsu_start), 32'(0));
    chk("rst_done_err", 32'({done, error}), 32'(0));
    rst = 1'b0;

    set_prog(OP_ADD, OP_ADD, OP_RET);
    run_prog(4'b1111, 1, mk(3, 2, 0, 0, 0, 19), "add_add_ret");

    set_prog(OP_LOAD, OP_RET, OP_ADD);
    set_lat(2, 5, 3, 7);
    run_prog(4'b1111, 1, mk(2, 1, 0, 1, 7, 20), "load_ret");

    set_lat(2, 0, 4, 1);
    run_prog(4'b0101, 1, mk(2, 1, 0, 1, 4, 0), "mask0101");

    set_lat(2, 0, 0, 0);
    run_prog(4'b0101, 1, mk(0, 0, 1, 1, 255, 0), "wait_timeout");

    set_prog(OP_ADD, OP_ADD, OP_ADD);
    run_prog(4'b1111, 0, mk(16, 15, 1, 0, 0, 81), "pc_overflow");

    run_prog(4'b0000, 1, mk(0, 0, 0, 0, 0, 1), "empty_mask");

    set_prog(OP_ADD, OP_STORE, OP_RET);
    set_lat(1, 1, 1, 1);
    run_prog(4'b1011, 1, mk(3, 2, 0, 1, 1, 20), "store");

    // Reset in the middle of a memory wait.
    set_prog(OP_ADD, OP_LOAD, OP_RET);
    set_lat(0, 0, 0, 0);
    @(negedge clk);
    thread_mask = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (simd_state != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_wait", 32'(simd_state), 32'(4));
    repeat (3) @(negedge clk);
    p0 = pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", 32'(simd_state), 32'(0));
    chk("rst_mid_pc", 32'(pc), 32'(0));
    chk("rst_mid_count", 32'(instr_count), 32'(0));
    chk("rst_mid_outs", 32'({fetch_req, lsu_start, done, error}), 32'(0));
    repeat (5) @(negedge clk);
    chk("rst_mid_no_pulse", pulses - p0, 0);
    chk("rst_mid_idle", 32'(simd_state), 32'(0));

    // start held high through DONE must not retrigger.
    set_prog(OP_ADD, OP_RET, OP_ADD);
    fetch_lat = 0;
    @(negedge clk);
    thread_mask = 4'hF; start = 1'b1;
    n = 0;
    while (simd_state != 3'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("held_state", 32'(simd_state), 32'(7));
    chk("held_count", 32'(instr_count), 32'(2));
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("restart_state", 32'(simd_state), 32'(1));
    chk("restart_done", 32'(done), 32'(0));
    start = 1'b0;
    n = 0;
    while (simd_state != 3'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("restart_count", 32'(instr_count), 32'(2));
    chk("restart_pc", 32'(pc), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
